hazard_ctrl: RTL and testbench

Pipeline hazard controller that consumes the ID/EX register contents and drives the write-enable and flush controls back into the PC, IF/ID and ID/EX registers. It also consumes the EX/MEM branch outcome and a data-memory busy flag. Three mechanisms are combined under a small FSM with fixed priority:

- load-use stall detection
- taken-branch squash of the three younger stages
- whole-pipe freeze on memory wait

It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//
// Pipeline hazard controller for a classic 5-stage pipeline. It watches the
// ID/EX load, the IF/ID source registers, the EX/MEM branch outcome and the
// data-memory busy flag. From these it drives load enables and flush
// (bubble-insert) controls for the PC, IF/ID, ID/EX and EX/MEM registers.
//
// The hazards are resolved in this fixed priority order:
//   reset > memory wait freeze > taken-branch squash > load-use stall > run
//
// Saturating event counters record the stalls and flushes taken, for
// performance debug.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   idexMemRead, idexRt           load in ID/EX and its destination register
//   ifidRs, ifidRt, ifidUsesRt    sources of the instruction in IF/ID
//   exmemBranch, exmemZero        branch outcome held in EX/MEM
//   memBusy                       data memory not ready this cycle
//   cntClr                        synchronous clear of both counters
//   pcWrite, ifidWrite, idexWrite register load enables
//   ifidFlush, idexFlush, exmemFlush  bubble-insert controls
//   state                         FSM state (RUN=00, LDSTALL=01, BRFLUSH=10)
//   stallCount, flushCount        saturating event counters

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idexMemRead,
    input  logic [4:0]       idexRt,
    input  logic [4:0]       ifidRs,
    input  logic [4:0]       ifidRt,
    input  logic             ifidUsesRt,
    input  logic             exmemBranch,
    input  logic             exmemZero,
    input  logic             memBusy,
    input  logic             cntClr,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             exmemFlush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        BRFLUSH = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             stall_inc;
    logic             flush_inc;

    logic taken;
    logic load_use;
    logic taken_ok;
    logic load_use_ok;

    assign taken    = exmemBranch & exmemZero;
    assign load_use = idexMemRead & (idexRt != 5'd0) &
                      ((idexRt == ifidRs) | (ifidUsesRt & (idexRt == ifidRt)));

    // The bubble stages that follow a stall or a squash carry no real
    // instruction. A hazard seen there is a stale copy of the one just handled,
    // so it is masked. A taken branch can still retire behind a load-use
    // bubble, so it stays visible in LDSTALL.
    assign taken_ok    = taken & (state_reg != BRFLUSH);
    assign load_use_ok = load_use & (state_reg != BRFLUSH) & (state_reg != LDSTALL);

    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        state_next = RUN;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (reset) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            exmemFlush = 1'b1;
        end else if (memBusy) begin
            // Whole-pipe freeze. Any pending hazard is re-evaluated once
            // memory is ready again.
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            state_next = state_reg;
        end else if (taken_ok) begin
            // Squash the three younger instructions and let the target load.
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            exmemFlush = 1'b1;
            state_next = BRFLUSH;
            flush_inc  = 1'b1;
        end else if (load_use_ok) begin
            // Hold PC and IF/ID. Insert a single bubble into ID/EX.
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexFlush  = 1'b1;
            state_next = LDSTALL;
            stall_inc  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= RUN;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            // A clear wins over a same-cycle increment, and that event is lost.
            if (cntClr) begin
                stall_cnt_reg <= '0;
                flush_cnt_reg <= '0;
            end else begin
                if (stall_inc && (stall_cnt_reg != CNT_MAX))
                    stall_cnt_reg <= stall_cnt_reg + 1'b1;
                if (flush_inc && (flush_cnt_reg != CNT_MAX))
                    flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign state      = state_reg;
    assign stallCount = stall_cnt_reg;
    assign flushCount = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (built with CNT_W=4 so that saturation is reachable).
// Stimulus drives one vector per cycle just after the rising edge and queues
// the expected outputs. A separate monitor samples the outputs at the falling
// edge, pops the queue and compares.

module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             idexMemRead;
    logic [4:0]       idexRt;
    logic [4:0]       ifidRs;
    logic [4:0]       ifidRt;
    logic             ifidUsesRt;
    logic             exmemBranch;
    logic             exmemZero;
    logic             memBusy;
    logic             cntClr;
    logic             pcWrite;
    logic             ifidWrite;
    logic             idexWrite;
    logic             ifidFlush;
    logic             idexFlush;
    logic             exmemFlush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .idexMemRead (idexMemRead),
        .idexRt      (idexRt),
        .ifidRs      (ifidRs),
        .ifidRt      (ifidRt),
        .ifidUsesRt  (ifidUsesRt),
        .exmemBranch (exmemBranch),
        .exmemZero   (exmemZero),
        .memBusy     (memBusy),
        .cntClr      (cntClr),
        .pcWrite     (pcWrite),
        .ifidWrite   (ifidWrite),
        .idexWrite   (idexWrite),
        .ifidFlush   (ifidFlush),
        .idexFlush   (idexFlush),
        .exmemFlush  (exmemFlush),
        .state       (state),
        .stallCount  (stallCount),
        .flushCount  (flushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] w;    // {pcWrite, ifidWrite, idexWrite}
        logic [2:0] f;    // {ifidFlush, idexFlush, exmemFlush}
        logic [1:0] st;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Drive one cycle of inputs and queue what the outputs must be that cycle.
    task automatic apply(input string name, input logic r, input logic mr,
                         input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ur,
                         input logic br, input logic z, input logic busy,
                         input logic clr, input logic [2:0] w,
                         input logic [2:0] f, input logic [1:0] st,
                         input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        @(posedge clk);
        #2;
        reset       = r;
        idexMemRead = mr;
        idexRt      = xrt;
        ifidRs      = rs;
        ifidRt      = rt;
        ifidUsesRt  = ur;
        exmemBranch = br;
        exmemZero   = z;
        memBusy     = busy;
        cntClr      = clr;
        e.name = name; e.w = w; e.f = f; e.st = st; e.sc = sc; e.fc = fc;
        q.push_back(e);
    endtask

    // Shorthands for the common input patterns.
    task automatic idle(input string name, input logic [1:0] st,
                        input logic [3:0] sc, input logic [3:0] fc);
        apply(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000, st, sc, fc);
    endtask

    task automatic lu(input string name, input logic [2:0] w, input logic [2:0] f,
                      input logic [1:0] st, input logic [3:0] sc, input logic [3:0] fc);
        // lw $5 in ID/EX, add $x,$5,... in IF/ID
        apply(name, 0, 1, 5, 5, 0, 1, 0, 0, 0, 0, w, f, st, sc, fc);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if ({pcWrite, ifidWrite, idexWrite} !== e.w ||
                    {ifidFlush, idexFlush, exmemFlush} !== e.f ||
                    state !== e.st || stallCount !== e.sc || flushCount !== e.fc) begin
                    n_fail++;
                    $display("FAIL %s: got W=%b F=%b st=%b sc=%0d fc=%0d, want W=%b F=%b st=%b sc=%0d fc=%0d",
                             e.name, {pcWrite, ifidWrite, idexWrite},
                             {ifidFlush, idexFlush, exmemFlush}, state, stallCount,
                             flushCount, e.w, e.f, e.st, e.sc, e.fc);
                end else begin
                    $display("vec %0d %s: W=%b F=%b st=%b sc=%0d fc=%0d ok", n_vec, e.name,
                             {pcWrite, ifidWrite, idexWrite},
                             {ifidFlush, idexFlush, exmemFlush}, state, stallCount, flushCount);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        reset = 1'b1; idexMemRead = 0; idexRt = 0; ifidRs = 0; ifidRt = 0;
        ifidUsesRt = 0; exmemBranch = 0; exmemZero = 0; memBusy = 0; cntClr = 0;

        // Reset levels
        apply("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111, 2'b00, 0, 0);
        apply("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111, 2'b00, 0, 0);
        idle("run_after_reset", 2'b00, 0, 0);

        // Basic load-use on rs. While in LDSTALL the stale hazard is masked.
        lu("lu_rs", 3'b001, 3'b010, 2'b00, 0, 0);
        lu("lu_masked_in_ldstall", 3'b111, 3'b000, 2'b01, 1, 0);
        idle("back_to_run", 2'b00, 1, 0);

        // Register 0 never stalls. An rt match is ignored unless rt is a source.
        apply("rt0_no_stall", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b111, 3'b000, 2'b00, 1, 0);
        apply("rt_unused", 0, 1, 5, 3, 5, 0, 0, 0, 0, 0, 3'b111, 3'b000, 2'b00, 1, 0);
        apply("lu_rt_used", 0, 1, 5, 3, 5, 1, 0, 0, 0, 0, 3'b001, 3'b010, 2'b00, 1, 0);
        idle("ldstall2", 2'b01, 2, 0);
        idle("run2", 2'b00, 2, 0);

        // Taken beats load-use. A taken held in BRFLUSH is masked.
        apply("taken_and_lu", 0, 1, 5, 5, 0, 1, 1, 1, 0, 0, 3'b111, 3'b111, 2'b00, 2, 0);
        apply("taken_masked_brflush", 0, 1, 5, 5, 0, 1, 1, 1, 0, 0, 3'b111, 3'b000, 2'b10, 2, 1);
        idle("run3", 2'b00, 2, 1);
        apply("branch_not_taken", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b111, 3'b000, 2'b00, 2, 1);

        // A taken branch out of LDSTALL
        lu("lu_before_taken", 3'b001, 3'b010, 2'b00, 2, 1);
        apply("taken_from_ldstall", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b111, 3'b111, 2'b01, 3, 1);
        idle("brflush2", 2'b10, 3, 2);
        idle("run4", 2'b00, 3, 2);

        // memBusy freezes everything, then the pending load-use is taken
        for (int i = 0; i < 3; i++)
            apply("busy_over_lu", 0, 1, 5, 5, 0, 1, 0, 0, 1, 0, 3'b000, 3'b000, 2'b00, 3, 2);
        lu("lu_after_busy", 3'b001, 3'b010, 2'b00, 3, 2);
        idle("ldstall_after_busy", 2'b01, 4, 2);
        idle("run5", 2'b00, 4, 2);

        // memBusy holds LDSTALL
        lu("lu_then_busy", 3'b001, 3'b010, 2'b00, 4, 2);
        apply("busy_hold_ldstall_a", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 3'b000, 2'b01, 5, 2);
        apply("busy_hold_ldstall_b", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 3'b000, 2'b01, 5, 2);
        idle("ldstall_released", 2'b01, 5, 2);
        idle("run6", 2'b00, 5, 2);

        // Drive stallCount up to 15 and past it: it must stick at all ones
        for (int i = 0; i < 12; i++) begin
            lu("sat_lu", 3'b001, 3'b010, 2'b00, 4'((5 + i > 15) ? 15 : 5 + i), 2);
            idle("sat_ldstall", 2'b01, 4'((6 + i > 15) ? 15 : 6 + i), 2);
        end
        idle("sat_run", 2'b00, 15, 2);

        // cntClr wins over a coincident stall increment
        apply("clr_with_lu", 0, 1, 5, 5, 0, 1, 0, 0, 0, 1, 3'b001, 3'b010, 2'b00, 15, 2);
        idle("after_clr", 2'b01, 0, 0);
        idle("run7", 2'b00, 0, 0);

        // Reset asserted mid-cycle while entering LDSTALL clears at once
        lu("lu_before_reset", 3'b001, 3'b010, 2'b00, 0, 0);
        apply("reset_mid_ldstall", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111, 2'b00, 0, 0);
        apply("reset_with_taken", 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 3'b111, 2'b00, 0, 0);
        idle("run_after_reset2", 2'b00, 0, 0);
        idle("run_after_reset3", 2'b00, 0, 0);

        // Let the monitor drain the queue, within a bounded time.
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d vectors unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
